// File: rtl/audio_clock_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_clk_pkg
// Description : Shared types and constants for the audio clock scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_clk_pkg;

    // Default prescaler / divide-value width
    localparam int CNT_W_DEF       = 8;
    // Default number of bclk periods per channel slot
    localparam int BITS_PER_CH_DEF = 16;
    // Smallest divide value the controller will run with
    localparam int DIV_MIN         = 1;

    // Controller operating state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/audio_clock_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_clock_scheduler_if
// Description : Divide-value configuration handshake (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_clock_scheduler_if
    import audio_clk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/audio_clock_scheduler_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Modulo counter 0..i_div with synchronous clear; o_tick marks
//               the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import audio_clk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  wire logic             clk_sys,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic [CNT_W-1:0] i_div,
    output logic                  o_tick
);
    logic [CNT_W-1:0] r_cnt;

    // A cleared counter never ticks, so nothing downstream moves while idle
    assign o_tick = !i_clear && (r_cnt == i_div);

    // Count up, wrapping to zero on the terminal count or when cleared
    always_ff @(posedge clk_sys) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/audio_clock_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : audio_clock_scheduler
// Description : Generates bclk / lrck and datapath strobes from clk_sys with
//               a run-time divide value that changes only on frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_clock_scheduler
    import audio_clk_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 4,
    parameter int BITS_PER_CH = BITS_PER_CH_DEF
) (
    input  wire logic              clk_sys,
    input  wire logic              rst,
    input  wire logic              en,
    audio_clock_scheduler_if.slave cfg,
    output logic [CNT_W-1:0]       div_active,
    output logic                   bclk,
    output logic                   lrck,
    output logic                   bclk_fall_en,
    output logic                   sample_strobe,
    output logic                   busy
);
    localparam int               c_bit_w     = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;
    localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(BITS_PER_CH - 1);
    localparam logic [CNT_W-1:0] c_div_reset = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_div_floor = CNT_W'(DIV_MIN);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_clear;
    logic               w_tick;
    logic               w_fall;
    logic               w_wrap;
    logic               w_xfer;
    logic [CNT_W-1:0]   w_cfg_div;
    logic [CNT_W-1:0]   r_div_active;
    logic [CNT_W-1:0]   r_pend_div;
    logic               r_pending;
    logic               r_bclk;
    logic               r_lrck;
    logic               r_fall_en;
    logic               r_strobe;
    logic [c_bit_w-1:0] r_bit_cnt;

    assign div_active    = r_div_active;
    assign bclk          = r_bclk;
    assign lrck          = r_lrck;
    assign bclk_fall_en  = r_fall_en;
    assign sample_strobe = r_strobe;
    assign busy          = (r_state != IDLE);
    assign cfg.cfg_ready = !r_pending;

    // Timing is held at zero while idle and on the cycle that enters idle
    assign w_clear   = (r_state == IDLE) || (w_state_next == IDLE);
    assign w_fall    = w_tick && r_bclk;
    assign w_wrap    = (r_bit_cnt == c_bit_last);
    assign w_xfer    = cfg.cfg_valid && !r_pending;
    assign w_cfg_div = (cfg.cfg_div == '0) ? c_div_floor : cfg.cfg_div;

    tick_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk_sys (clk_sys),
        .rst     (rst),
        .i_clear (w_clear),
        .i_div   (r_div_active),
        .o_tick  (w_tick)
    );

    // State register
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a stop only takes effect once the current frame has closed
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (en) w_state_next = RUN;
            RUN:     if (!en) w_state_next = DRAIN;
            DRAIN: begin
                if (en) begin
                    w_state_next = RUN;
                end else if (r_strobe) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // bclk / lrck generation and the strobes aligned to bclk falling edges
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_bclk    <= 1'b0;
            r_lrck    <= 1'b0;
            r_bit_cnt <= '0;
            r_fall_en <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_fall_en <= w_fall;
            r_strobe  <= w_fall && w_wrap && r_lrck;
            if (w_clear) begin
                r_bclk    <= 1'b0;
                r_lrck    <= 1'b0;
                r_bit_cnt <= '0;
            end else if (w_tick) begin
                r_bclk <= !r_bclk;
                if (r_bclk) begin
                    if (w_wrap) begin
                        r_bit_cnt <= '0;
                        r_lrck    <= !r_lrck;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                    end
                end
            end
        end
    end

    // Divide value: direct load when idle, otherwise parked until a frame ends.
    // Only a value already parked before the strobe cycle is applied there.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_div_active <= c_div_reset;
            r_pend_div   <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (r_pending && r_strobe) begin
                r_div_active <= r_pend_div;
                r_pending    <= 1'b0;
            end
            if (w_xfer) begin
                if (r_state == IDLE) begin
                    r_div_active <= w_cfg_div;
                end else begin
                    r_pend_div <= w_cfg_div;
                    r_pending  <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_audio_clock_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_clock_scheduler
// Description : Scoreboard bench for audio_clock_scheduler. Expected frame
//               descriptors are queued by the stimulus; a monitor measures
//               each completed frame and compares against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_clock_scheduler;

    typedef struct {
        int frame_len;
        int bclk_per;
    } exp_t;

    logic       clk_sys;
    logic       rst;
    logic       en;
    logic [7:0] div_active;
    logic       bclk;
    logic       lrck;
    logic       bclk_fall_en;
    logic       sample_strobe;
    logic       busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb_q[$];

    audio_clock_scheduler_if #(.CNT_W(8)) cfg_if ();

    audio_clock_scheduler #(
        .CNT_W       (8),
        .DEFAULT_DIV (4),
        .BITS_PER_CH (16)
    ) dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .en            (en),
        .cfg           (cfg_if),
        .div_active    (div_active),
        .bclk          (bclk),
        .lrck          (lrck),
        .bclk_fall_en  (bclk_fall_en),
        .sample_strobe (sample_strobe),
        .busy          (busy)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int m_prev_busy  = 0;
    int m_prev_lrck  = 0;
    int m_last_fall  = 0;
    int m_last_strb  = 0;
    int m_lrck_rise  = 0;
    int m_min        = 1000000;
    int m_max        = 0;
    int m_iv;
    exp_t m_e;

    always @(negedge clk_sys) begin
        if (busy && (m_prev_busy == 0)) begin
            m_last_fall = cyc;
            m_last_strb = cyc;
            m_min       = 1000000;
            m_max       = 0;
        end
        m_prev_busy = int'(busy);
        if (lrck && (m_prev_lrck == 0)) m_lrck_rise = cyc;
        m_prev_lrck = int'(lrck);
        if (bclk_fall_en) begin
            m_iv = cyc - m_last_fall;
            if (m_iv < m_min) m_min = m_iv;
            if (m_iv > m_max) m_max = m_iv;
            m_last_fall = cyc;
        end
        if (sample_strobe) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got sample_strobe at cycle %0d, expected none", cyc);
            end else begin
                m_e = sb_q.pop_front();
                check("frame_len",      cyc - m_last_strb, m_e.frame_len);
                check("bclk_per_min",   m_min,             m_e.bclk_per);
                check("bclk_per_max",   m_max,             m_e.bclk_per);
                check("lrck_high_len",  cyc - m_lrck_rise, m_e.frame_len / 2);
            end
            m_last_strb = cyc;
            m_min       = 1000000;
            m_max       = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_frame(input int frame_len, input int bclk_per);
        exp_t e;
        e.frame_len = frame_len;
        e.bclk_per  = bclk_per;
        sb_q.push_back(e);
    endtask

    task automatic send_cfg(input logic [7:0] val);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = val;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string name, input int budget);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            step();
            n++;
            seen = sample_strobe;
        end
        check(name, int'(seen), 1);
    endtask

    task automatic wait_falls(input string name, input int count, input int budget);
        int n    = 0;
        int hits = 0;
        while (hits < count && n < budget) begin
            step();
            n++;
            if (bclk_fall_en) hits++;
        end
        check(name, hits, count);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_bclk"},       int'(bclk),            0);
        check({tag, "_lrck"},       int'(lrck),            0);
        check({tag, "_fall_en"},    int'(bclk_fall_en),    0);
        check({tag, "_strobe"},     int'(sample_strobe),   0);
        check({tag, "_busy"},       int'(busy),            0);
        check({tag, "_cfg_ready"},  int'(cfg_if.cfg_ready), 1);
        check({tag, "_div_active"}, int'(div_active),      4);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_bclk"}, int'(bclk), 0);
        check({tag, "_lrck"}, int'(lrck), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst              = 1'b1;
        en               = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = 8'd0;
        repeat (3) step();
        check_reset("por");
        rst = 1'b0;
        step();

        // Default divide: two frames, stop requested right after the first
        push_frame(320, 10);
        push_frame(320, 10);
        en = 1'b1;
        wait_strobe("a_strobe1", 400);
        en = 1'b0;
        step();
        check("a_drain_busy", int'(busy), 1);
        wait_strobe("a_strobe2", 400);
        step();
        check_idle("a_idle");

        // Divide 9 loaded while idle; stop requested early, frame completes
        send_cfg(8'd9);
        check("b_div_active", int'(div_active), 9);
        check("b_cfg_ready", int'(cfg_if.cfg_ready), 1);
        push_frame(640, 20);
        en = 1'b1;
        repeat (3) step();
        en = 1'b0;
        step();
        check("b_drain_busy", int'(busy), 1);
        wait_strobe("b_strobe", 800);
        step();
        check_idle("b_idle");

        // Back to 4, then change to 2 mid-frame; applies after the boundary
        send_cfg(8'd4);
        check("c_div_active_idle", int'(div_active), 4);
        push_frame(320, 10);
        push_frame(192, 6);
        en = 1'b1;
        repeat (100) step();
        send_cfg(8'd2);
        check("c_ready_pending", int'(cfg_if.cfg_ready), 0);
        check("c_div_held", int'(div_active), 4);
        wait_strobe("c_strobe1", 400);
        check("c_ready_at_strobe", int'(cfg_if.cfg_ready), 0);
        check("c_div_at_strobe", int'(div_active), 4);
        en = 1'b0;
        step();
        check("c_div_applied", int'(div_active), 2);
        check("c_ready_back", int'(cfg_if.cfg_ready), 1);
        wait_strobe("c_strobe2", 300);
        step();
        check_idle("c_idle");

        // Stop at bit 5 of the left slot, resume during drain without a gap
        push_frame(192, 6);
        push_frame(192, 6);
        en = 1'b1;
        wait_falls("d_five_falls", 5, 100);
        en = 1'b0;
        repeat (20) step();
        check("d_drain_busy", int'(busy), 1);
        en = 1'b1;
        wait_strobe("d_strobe1", 300);
        en = 1'b0;
        wait_strobe("d_strobe2", 300);
        step();
        check_idle("d_idle");

        // Zero divide request is clamped to 1
        send_cfg(8'd0);
        check("e_div_clamped", int'(div_active), 1);
        push_frame(128, 4);
        en = 1'b1;
        repeat (3) step();
        en = 1'b0;
        wait_strobe("e_strobe", 200);
        step();
        check_idle("e_idle");

        // Reset mid-frame with a pending value: everything returns to defaults
        en = 1'b1;
        repeat (30) step();
        send_cfg(8'd7);
        check("f_ready_pending", int'(cfg_if.cfg_ready), 0);
        rst = 1'b1;
        en  = 1'b0;
        step();
        check_reset("f_rst");
        rst = 1'b0;
        push_frame(320, 10);
        en = 1'b1;
        repeat (3) step();
        en = 1'b0;
        wait_strobe("f_strobe", 400);
        step();
        check("f_div_after", int'(div_active), 4);
        check("f_ready_after", int'(cfg_if.cfg_ready), 1);
        check_idle("f_idle");

        repeat (5) step();
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
